regfile_wb_arbiter: RTL

- Sole owner of the register-file write port. Shares it between the in-order pipeline writeback and a long-latency unit (divider/load) whose results arrive out of band.
- Keeps a per-register pending scoreboard for long-latency destinations and produces the decode-stage hazard stall.
- Sits between the WB stage / long-latency unit and the regfile write inputs (we, valid, dstreg_num, dstreg_value).

---
 rtl/regfile_wb_arbiter_pkg.sv | 26 ++
 rtl/regfile_wb_arbiter_wb_result_fifo.sv | 63 ++++++
 rtl/regfile_wb_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the regfile writeback arbiter and its result buffer.
package regfile_wb_arbiter_pkg;

   localparam int XLEN      = 32;
   localparam int REG_NUM_W = 5;
   localparam int REG_COUNT = 2 ** REG_NUM_W;
   localparam logic [REG_NUM_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_NUM_W-1:0] dst;
      logic [XLEN-1:0]      value;
   } wb_entry_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_PIPE = 2'd1,
      GNT_BUF  = 2'd2
   } grant_e;

   // A register is busy when it is not x0 and its pending bit is set.
   function automatic logic reg_busy(input logic [REG_COUNT-1:0] pend,
                                     input logic [REG_NUM_W-1:0] r);
      return (r != REG_ZERO) & pend[r];
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_result_fifo.sv
// Synchronous FIFO holding long-latency results until they win the regfile write port.
module wb_result_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 37
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push_s;
   logic             do_pop_s;

   // Extra pointer bit distinguishes full from empty when the index bits match.
   assign empty_o    = (wr_ptr_q == rd_ptr_q);
   assign full_o     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign do_push_s  = push_i & ~full_o;
   assign do_pop_s   = pop_i & ~empty_o;
   assign pop_data_o = mem_q[rd_ptr_q[PTR_W-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (do_push_s) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: pipeline WB vs buffered long-latency results, plus pending scoreboard.
// Optional macro RF_WB_BYPASS_EN adds same-cycle forwarding of the result being written.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int BUF_DEPTH    = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pipe_wb_valid,
   input  logic                 pipe_wb_we,
   input  logic [REG_NUM_W-1:0] pipe_wb_dst,
   input  logic [XLEN-1:0]      pipe_wb_value,
   output logic                 pipe_hold,
   input  logic                 lu_issue,
   input  logic [REG_NUM_W-1:0] lu_issue_dst,
   input  logic                 lu_result_valid,
   output logic                 lu_result_ready,
   input  logic [REG_NUM_W-1:0] lu_result_dst,
   input  logic [XLEN-1:0]      lu_result_value,
   input  logic                 dec_valid,
   input  logic [REG_NUM_W-1:0] dec_src1,
   input  logic [REG_NUM_W-1:0] dec_src2,
   input  logic [REG_NUM_W-1:0] dec_dst,
   output logic                 hazard_stall,
   output logic                 rf_we,
   output logic                 rf_valid,
   output logic [REG_NUM_W-1:0] rf_dst,
   output logic [XLEN-1:0]      rf_value
`ifdef RF_WB_BYPASS_EN
   ,
   output logic                 fwd1_hit,
   output logic                 fwd2_hit,
   output logic [XLEN-1:0]      fwd_value
`endif
);

   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   wb_entry_t              push_entry_s;
   wb_entry_t              head_s;
   logic                   push_s;
   logic                   pop_s;
   logic                   full_s;
   logic                   empty_s;
   logic                   pipe_req_s;
   grant_e                 grant_s;
   logic [STARVE_W-1:0]    starve_q, starve_d;
   logic [REG_COUNT-1:0]   pending_q, pending_d;
   logic                   src1_block_s;
   logic                   src2_block_s;
   logic                   dst_block_s;

   assign pipe_req_s      = pipe_wb_valid & pipe_wb_we & (pipe_wb_dst != REG_ZERO);
   assign lu_result_ready = ~full_s;
   // x0 results are acknowledged but never enter the buffer.
   assign push_s          = lu_result_valid & ~full_s & (lu_result_dst != REG_ZERO);
   assign push_entry_s    = '{dst: lu_result_dst, value: lu_result_value};
   assign pipe_hold       = ~empty_s & (starve_q == STARVE_MAX);
   assign pop_s           = (grant_s == GNT_BUF);

   wb_result_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH ($bits(wb_entry_t))
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push_s),
      .push_data_i (push_entry_s),
      .pop_i       (pop_s),
      .pop_data_o  (head_s),
      .full_o      (full_s),
      .empty_o     (empty_s)
   );

   always_comb begin
      grant_s = GNT_NONE;
      if (pipe_hold) begin
         grant_s = GNT_BUF;
      end else if (pipe_req_s) begin
         grant_s = GNT_PIPE;
      end else if (!empty_s) begin
         grant_s = GNT_BUF;
      end else begin
         grant_s = GNT_NONE;
      end
   end

   always_comb begin
      rf_we    = 1'b0;
      rf_dst   = REG_ZERO;
      rf_value = '0;
      case (grant_s)
         GNT_PIPE: begin
            rf_we    = 1'b1;
            rf_dst   = pipe_wb_dst;
            rf_value = pipe_wb_value;
         end
         GNT_BUF: begin
            rf_we    = 1'b1;
            rf_dst   = head_s.dst;
            rf_value = head_s.value;
         end
         default: begin
            rf_we    = 1'b0;
            rf_dst   = REG_ZERO;
            rf_value = '0;
         end
      endcase
   end

   assign rf_valid = rf_we;

   always_comb begin
      starve_d = starve_q;
      if (empty_s || pop_s) begin
         starve_d = '0;
      end else if (starve_q != STARVE_MAX) begin
         starve_d = starve_q + STARVE_W'(1);
      end else begin
         starve_d = starve_q;
      end
   end

   // Clear of the written head is applied before the issue set so set wins on a collision.
   always_comb begin
      pending_d = pending_q;
      if (pop_s) begin
         pending_d[head_s.dst] = 1'b0;
      end else begin
         pending_d = pending_q;
      end
      if (lu_issue && (lu_issue_dst != REG_ZERO)) begin
         pending_d[lu_issue_dst] = 1'b1;
      end else begin
         pending_d[0] = 1'b0;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q  <= '0;
         pending_q <= '0;
      end else begin
         starve_q  <= starve_d;
         pending_q <= pending_d;
      end
   end

`ifdef RF_WB_BYPASS_EN
   logic src1_clr_s;
   logic src2_clr_s;

   assign src1_clr_s   = pop_s & (head_s.dst == dec_src1);
   assign src2_clr_s   = pop_s & (head_s.dst == dec_src2);
   assign src1_block_s = reg_busy(pending_q, dec_src1) & ~src1_clr_s;
   assign src2_block_s = reg_busy(pending_q, dec_src2) & ~src2_clr_s;
   assign fwd1_hit     = dec_valid & reg_busy(pending_q, dec_src1) & src1_clr_s;
   assign fwd2_hit     = dec_valid & reg_busy(pending_q, dec_src2) & src2_clr_s;
   assign fwd_value    = rf_value;
`else
   assign src1_block_s = reg_busy(pending_q, dec_src1);
   assign src2_block_s = reg_busy(pending_q, dec_src2);
`endif

   assign dst_block_s  = reg_busy(pending_q, dec_dst);
   assign hazard_stall = dec_valid & (src1_block_s | src2_block_s | dst_block_s);

endmodule
